instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction-fetch stage for the simple RISC machine. Owns the PC and the single memory port.
//  Fetches 16-bit instructions from start_pc and hands them to the decoder/datapath over a
//  valid/ready handshake. Arbitrates datapath LDR/STR accesses onto the same port.
//  Detects HALT and stops fetching until reset.
// PARAMETERS
//  ADDR_W    8       memory address / PC width
//  DATA_W    16      instruction and data word width
//  HALT_OPC  3'b111  opcode field ir[15:13] that means HALT
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous, active-low reset
//  start_pc     in   ADDR_W  first fetch address; sampled on the first edge after reset release
//  mem_addr     out  ADDR_W  memory address
//  mem_rd       out  1       memory read strobe; RAM returns mem_rdata on the next edge
//  mem_wr       out  1       memory write strobe
//  mem_wdata    out  DATA_W  write data
//  mem_rdata    in   DATA_W  read data, 1-cycle latency
//  ir           out  DATA_W  instruction register
//  ir_valid     out  1       ir holds an undelivered instruction
//  ir_ready     in   1       datapath accepts ir (handshake = ir_valid & ir_ready at an edge)
//  pc           out  ADDR_W  address ir was fetched from
//  d_req        in   1       datapath data-access request; held until d_ack
//  d_we         in   1       1 = STR (write), 0 = LDR (read)
//  d_addr       in   ADDR_W  data address
//  d_wdata      in   DATA_W  store data
//  d_rdata      out  DATA_W  load data, valid while d_ack=1
//  d_ack        out  1       one-cycle completion pulse
//  halted       out  1       HALT fetched; fetch stopped
//  instr_count  out  16      count of handshaken instructions (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): state S_RST. All registered outputs are 0: ir, ir_valid, pc, fpc, d_rdata,
//    d_ack, halted, instr_count. mem_rd and mem_wr drop immediately. Reset mid-access aborts it.
//  - States: S_RST, S_FETCH, S_WAIT, S_VALID, S_DWAIT, S_HALT. ret_state is a 1-bit register
//    (FETCH or VALID).
//  - S_RST: fpc <= start_pc; -> S_FETCH.
//  - S_FETCH:
//      - d_req & !d_ack: drive the data access; ret_state <= FETCH; -> S_DWAIT.
//      - Otherwise: mem_addr=fpc, mem_rd=1; -> S_WAIT.
//  - S_WAIT, on the edge:
//      - If mem_rdata[15:13]==HALT_OPC: halted <= 1; -> S_HALT. HALT is never presented on ir.
//      - Otherwise: ir <= mem_rdata, pc <= fpc, fpc <= fpc+1 (0xFF wraps to 0x00),
//        ir_valid <= 1; -> S_VALID.
//  - S_VALID: ir and pc are held stable.
//      - ir_ready only: ir_valid <= 0; -> S_FETCH.
//      - d_req & !d_ack only: data access; ret_state <= VALID; -> S_DWAIT. ir_valid stays 1.
//      - Both: handshake completes and data access issues; ret_state <= FETCH.
//  - Data access (comb, in S_FETCH/S_VALID): mem_addr=d_addr, mem_wr=d_we, mem_rd=!d_we,
//    mem_wdata=d_wdata. Data has priority over fetch.
//  - S_DWAIT: d_rdata <= mem_rdata (write: unchanged), d_ack <= 1 for one cycle; -> ret_state.
//    d_req is ignored while d_ack=1.
//  - Latency: first ir_valid 3 edges after the reset-release edge. Back-to-back fetch with
//    ir_ready=1 delivers one instruction per 3 cycles. d_ack is high 2 cycles after the request
//    is sampled.
//  - Outside access cycles, mem_rd=mem_wr=0 and mem_addr=fpc.
//  - S_HALT: absorbing until rst_n. halted=1, ir_valid=0, no memory strobes, d_req ignored.
//  - A STR to an address already prefetched into ir does not refresh ir; self-modifying code is
//    unsupported.
// CONFIGURATION
//  - FETCH_PERF_CNT_EN defined: instr_count +1 on each ir handshake, saturating at 0xFFFF;
//    reset 0.
//  - Not defined: instr_count is tied to 16'h0000 and no counter logic is built.
// TESTING
//  1. mem[04]=0xD0F0, mem[05]=0xD30F, start_pc=0x04, ir_ready=1 -> ir=0xD0F0,pc=0x04 at edge 3; then ir=0xD30F,pc=0x05
//  2. ir_ready=0 for 5 cycles in S_VALID -> ir,pc unchanged, ir_valid=1, mem_rd=0 throughout
//  3. In S_VALID, d_req=1,d_we=0,d_addr=0x2E, mem[2E]=0xAAAA -> d_ack=1, d_rdata=0xAAAA; ir still valid
//  4. STR d_addr=0x30,d_wdata=0x7FF8 then LDR 0x30 -> mem[30]=0x7FF8, d_rdata=0x7FF8
//  5. mem[10]=0xE000 -> halted=1, ir_valid=0, mem_rd=0 forever; reset, start_pc=0x14 -> fetch restarts at 0x14
//  6. start_pc=0xFF -> second fetch at mem_addr 0x00; with FETCH_PERF_CNT_EN, 2 handshakes give instr_count=2

Source files
------------

// File: rtl/instr_fetch_if.sv
// Purpose : bundles the fetch stage's memory port, ir handshake and data-access port.
// Latency : n/a (wires only).
// Backpressure: ir_valid/ir_ready on the instruction side; d_req held until d_ack on data side.
// Ports (master = fetch stage):
//   mem_addr/mem_rd/mem_wr/mem_wdata out, mem_rdata in   single RAM port, 1-cycle read
//   ir/ir_valid/pc out, ir_ready in                       instruction handshake
//   d_req/d_we/d_addr/d_wdata in, d_rdata/d_ack out       datapath LDR/STR port
interface instr_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  logic              ir_ready;
  logic [ADDR_W-1:0] pc;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata,
    output ir, ir_valid, pc,
    input  ir_ready,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ack
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata,
    input  ir, ir_valid, pc,
    output ir_ready,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ack
  );
endinterface

// File: rtl/instr_fetch.sv
// Purpose : instruction fetch stage; owns PC and the single memory port, arbitrates LDR/STR.
// Latency : first ir_valid 3 edges after reset release; 1 instr / 3 cycles; d_ack 2 edges after req.
// Backpressure: ir held in S_VALID until ir_ready; data accesses take priority over fetch.
// Ports: clk, rst_n (async active-low), start_pc (sampled leaving reset), bus (instr_fetch_if
//   master), halted (HALT seen, fetch stopped), instr_count (handshake counter).
// Optional feature: define FETCH_PERF_CNT_EN to build the saturating instr_count counter;
//   otherwise instr_count is tied to zero.
module instr_fetch #(
  parameter int       ADDR_W   = 8,
  parameter int       DATA_W   = 16,
  parameter logic [2:0] HALT_OPC = 3'b111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] start_pc,
  instr_fetch_if.master     bus,
  output logic              halted,
  output logic [15:0]       instr_count
);

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_WAIT, S_VALID, S_DWAIT, S_HALT
  } state_t;

  localparam logic RET_FETCH = 1'b0;
  localparam logic RET_VALID = 1'b1;

  state_t            state_q, state_d;
  logic              ret_q, ret_d;
  logic              dwe_q, dwe_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_ack_q, d_ack_d;
  logic              halted_q, halted_d;

  logic d_go;     // data access issued this cycle
  logic hs;       // ir handshake at this edge
  logic is_halt;  // word returning in S_WAIT is HALT

  // d_ack_q masks the still-held d_req during the completion cycle.
  assign d_go    = ((state_q == S_FETCH) || (state_q == S_VALID)) && bus.d_req && !d_ack_q;
  assign hs      = (state_q == S_VALID) && bus.ir_ready;
  assign is_halt = (bus.mem_rdata[DATA_W-1 -: 3] == HALT_OPC);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RST;
      ret_q      <= RET_FETCH;
      dwe_q      <= 1'b0;
      fpc_q      <= '0;
      pc_q       <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      d_rdata_q  <= '0;
      d_ack_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      dwe_q      <= dwe_d;
      fpc_q      <= fpc_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      d_rdata_q  <= d_rdata_d;
      d_ack_q    <= d_ack_d;
      halted_q   <= halted_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    case (state_q)
      S_RST:   state_d = S_FETCH;
      S_FETCH: begin
        if (d_go) begin
          ret_d   = RET_FETCH;
          state_d = S_DWAIT;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT:  state_d = is_halt ? S_HALT : S_VALID;
      S_VALID: begin
        if (d_go) begin
          // A simultaneous handshake empties ir, so come back to fetch.
          ret_d   = hs ? RET_FETCH : RET_VALID;
          state_d = S_DWAIT;
        end else if (hs) begin
          state_d = S_FETCH;
        end
      end
      S_DWAIT: state_d = (ret_q == RET_VALID) ? S_VALID : S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  // Register-update and memory-port output logic
  always_comb begin
    fpc_d      = fpc_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    d_rdata_d  = d_rdata_q;
    d_ack_d    = 1'b0;
    halted_d   = halted_q;
    dwe_d      = dwe_q;

    bus.mem_addr  = fpc_q;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_wdata = '0;

    if (state_q == S_RST) fpc_d = start_pc;

    if (d_go) begin
      bus.mem_addr  = bus.d_addr;
      bus.mem_wr    = bus.d_we;
      bus.mem_rd    = !bus.d_we;
      bus.mem_wdata = bus.d_wdata;
      dwe_d         = bus.d_we;
    end else if (state_q == S_FETCH) begin
      bus.mem_rd = 1'b1;
    end

    if (state_q == S_WAIT) begin
      if (is_halt) begin
        halted_d = 1'b1;
      end else begin
        ir_d       = bus.mem_rdata;
        pc_d       = fpc_q;
        fpc_d      = fpc_q + 1'b1;
        ir_valid_d = 1'b1;
      end
    end

    if (hs) ir_valid_d = 1'b0;

    if (state_q == S_DWAIT) begin
      d_ack_d = 1'b1;
      if (!dwe_q) d_rdata_d = bus.mem_rdata;
    end
  end

  assign bus.ir       = ir_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.pc       = pc_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.d_ack    = d_ack_q;
  assign halted       = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (hs && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign instr_count = cnt_q;
`else
  assign instr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Purpose : directed self-checking bench for instr_fetch with a 256x16 1-cycle-read RAM model.
// Latency : n/a.
// Backpressure: bench drives ir_ready/d_req directly on falling edges.
module tb_instr_fetch;
  logic        clk;
  logic        rst_n;
  logic [7:0]  start_pc;
  logic        halted;
  logic [15:0] instr_count;

  int n_chk  = 0;
  int n_fail = 0;

  instr_fetch_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_pc    (start_pc),
    .bus         (bus),
    .halted      (halted),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model; ld_* is a bench-only preload port used while the DUT sits in reset.
  logic [15:0] mem [256];
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [15:0] ld_dat;

  always @(posedge clk) begin
    if (ld_en)            mem[ld_addr]      <= ld_dat;
    else if (bus.mem_wr)  mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd)       bus.mem_rdata     <= mem[bus.mem_addr];
  end

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    ld_addr = a;
    ld_dat  = d;
    ld_en   = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [15:0] cnt_exp2;

  initial begin
`ifdef FETCH_PERF_CNT_EN
    cnt_exp2 = 16'd2;
`else
    cnt_exp2 = 16'd0;
`endif
    rst_n       = 1'b0;
    start_pc    = 8'h04;
    ld_en       = 1'b0;
    ld_addr     = '0;
    ld_dat      = '0;
    bus.ir_ready = 1'b1;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;

    for (int i = 0; i < 256; i++) poke(8'(i), 16'h0000);
    poke(8'h04, 16'hD0F0);
    poke(8'h05, 16'hD30F);
    poke(8'h06, 16'h1234);
    poke(8'h2E, 16'hAAAA);
    poke(8'h10, 16'hE000);
    poke(8'h14, 16'h4141);
    poke(8'hFF, 16'h5555);
    poke(8'h00, 16'h6666);
    @(negedge clk);

    // Reset state
    check("rst_ir",       32'(bus.ir),       'h0);
    check("rst_ir_valid", 32'(bus.ir_valid), 'h0);
    check("rst_pc",       32'(bus.pc),       'h0);
    check("rst_halted",   32'(halted),       'h0);
    check("rst_d_ack",    32'(bus.d_ack),    'h0);
    check("rst_d_rdata",  32'(bus.d_rdata),  'h0);
    check("rst_mem_rd",   32'(bus.mem_rd),   'h0);
    check("rst_mem_wr",   32'(bus.mem_wr),   'h0);
    check("rst_cnt",      32'(instr_count),  'h0);

    // 1: fetch from 0x04 with ir_ready=1
    rst_n = 1'b1;
    step(1);
    check("t1_rd",    32'(bus.mem_rd),   'h1);
    check("t1_addr",  32'(bus.mem_addr), 'h04);
    step(1);
    check("t1_wait_valid", 32'(bus.ir_valid), 'h0);
    step(1);
    check("t1_ir0",   32'(bus.ir),       'hD0F0);
    check("t1_pc0",   32'(bus.pc),       'h04);
    check("t1_vld0",  32'(bus.ir_valid), 'h1);
    step(1);
    check("t1_hs_vld", 32'(bus.ir_valid), 'h0);
    check("t1_addr1",  32'(bus.mem_addr), 'h05);
    step(2);
    check("t1_ir1",   32'(bus.ir),       'hD30F);
    check("t1_pc1",   32'(bus.pc),       'h05);

    // 2: stall in S_VALID
    bus.ir_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("t2_ir",  32'(bus.ir),       'hD30F);
      check("t2_pc",  32'(bus.pc),       'h05);
      check("t2_vld", 32'(bus.ir_valid), 'h1);
      check("t2_rd",  32'(bus.mem_rd),   'h0);
    end

    // 3: LDR 0x2E while ir is valid
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 8'h2E;
    #1;
    check("t3_rd",   32'(bus.mem_rd),   'h1);
    check("t3_addr", 32'(bus.mem_addr), 'h2E);
    step(1);
    check("t3_ack0", 32'(bus.d_ack),    'h0);
    step(1);
    check("t3_ack",  32'(bus.d_ack),    'h1);
    check("t3_data", 32'(bus.d_rdata),  'hAAAA);
    check("t3_vld",  32'(bus.ir_valid), 'h1);
    check("t3_ir",   32'(bus.ir),       'hD30F);
    bus.d_req = 1'b0;
    step(1);
    check("t3_ack_pulse", 32'(bus.d_ack), 'h0);

    // 4: STR 0x30 then LDR 0x30
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 8'h30;
    bus.d_wdata = 16'h7FF8;
    #1;
    check("t4_wr",   32'(bus.mem_wr), 'h1);
    check("t4_nord", 32'(bus.mem_rd), 'h0);
    step(2);
    check("t4_str_ack",  32'(bus.d_ack),   'h1);
    check("t4_str_hold", 32'(bus.d_rdata), 'hAAAA);
    check("t4_mem30",    32'(mem[8'h30]),  'h7FF8);
    bus.d_req = 1'b0;
    step(1);
    bus.d_req = 1'b1;
    bus.d_we  = 1'b0;
    step(2);
    check("t4_ldr_ack",  32'(bus.d_ack),   'h1);
    check("t4_ldr_data", 32'(bus.d_rdata), 'h7FF8);
    bus.d_req = 1'b0;
    step(1);
`ifdef FETCH_PERF_CNT_EN
    check("t4_cnt1", 32'(instr_count), 'h1);
`else
    check("t4_cnt1", 32'(instr_count), 'h0);
`endif

    // Handshake and data request on the same edge: back to fetch afterwards
    bus.ir_ready = 1'b1;
    bus.d_req    = 1'b1;
    bus.d_addr   = 8'h2E;
    step(1);
    check("both_vld", 32'(bus.ir_valid), 'h0);
    step(1);
    check("both_ack",  32'(bus.d_ack),    'h1);
    check("both_data", 32'(bus.d_rdata),  'hAAAA);
    bus.d_req = 1'b0;
    #1;
    check("both_fetch_rd",   32'(bus.mem_rd),   'h1);
    check("both_fetch_addr", 32'(bus.mem_addr), 'h06);
    step(2);
    check("both_ir", 32'(bus.ir), 'h1234);
    check("both_pc", 32'(bus.pc), 'h06);
    check("both_cnt", 32'(instr_count), 32'(cnt_exp2));

    // 5: HALT at 0x10, then restart at 0x14
    rst_n    = 1'b0;
    start_pc = 8'h10;
    step(1);
    rst_n = 1'b1;
    step(3);
    check("t5_halted", 32'(halted),       'h1);
    check("t5_vld",    32'(bus.ir_valid), 'h0);
    check("t5_rd",     32'(bus.mem_rd),   'h0);
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b1;
    bus.d_addr = 8'h31;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("t5_h_rd",  32'(bus.mem_rd), 'h0);
      check("t5_h_wr",  32'(bus.mem_wr), 'h0);
      check("t5_h_ack", 32'(bus.d_ack),  'h0);
      check("t5_h_hlt", 32'(halted),     'h1);
    end
    bus.d_req = 1'b0;
    rst_n     = 1'b0;
    start_pc  = 8'h14;
    step(1);
    rst_n = 1'b1;
    step(3);
    check("t5_re_ir",  32'(bus.ir),       'h4141);
    check("t5_re_pc",  32'(bus.pc),       'h14);
    check("t5_re_vld", 32'(bus.ir_valid), 'h1);
    check("t5_re_hlt", 32'(halted),       'h0);

    // 6: PC wrap from 0xFF and handshake count
    rst_n    = 1'b0;
    start_pc = 8'hFF;
    step(1);
    rst_n = 1'b1;
    step(1);
    check("t6_addr_ff", 32'(bus.mem_addr), 'hFF);
    step(2);
    check("t6_ir_ff", 32'(bus.ir), 'h5555);
    check("t6_pc_ff", 32'(bus.pc), 'hFF);
    step(1);
    check("t6_wrap_rd",   32'(bus.mem_rd),   'h1);
    check("t6_wrap_addr", 32'(bus.mem_addr), 'h00);
    step(2);
    check("t6_ir_00", 32'(bus.ir), 'h6666);
    check("t6_pc_00", 32'(bus.pc), 'h00);
    step(1);
    check("t6_cnt", 32'(instr_count), 32'(cnt_exp2));

    // Reset asserted mid-fetch drops the strobe immediately
    check("t6_pre_rd", 32'(bus.mem_rd), 'h1);
    rst_n = 1'b0;
    #1;
    check("abort_rd",  32'(bus.mem_rd),  'h0);
    check("abort_cnt", 32'(instr_count), 'h0);
    check("abort_pc",  32'(bus.pc),      'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
